// File: rtl/fir_pkg.sv
// fir_pkg: widths and round/saturate arithmetic shared by the FIR output path.
package fir_pkg;
    localparam int SAXI_DATA_WIDTH = 32;
    localparam int MAXI_DATA_WIDTH = 16;
    localparam int S_KEEP_WIDTH = SAXI_DATA_WIDTH / 8;
    localparam int M_KEEP_WIDTH = MAXI_DATA_WIDTH / 8;
    localparam int RND_W = SAXI_DATA_WIDTH + 1;
    typedef logic signed [RND_W-1:0] rnd_t;
    typedef struct packed {
        logic sat;
        logic [MAXI_DATA_WIDTH-1:0] dout;
    } sat_t;
    localparam logic [MAXI_DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(MAXI_DATA_WIDTH-1){1'b1}}};
    localparam logic [MAXI_DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(MAXI_DATA_WIDTH-1){1'b0}}};
    localparam rnd_t SMAX = rnd_t'(OUT_MAX);
    localparam rnd_t SMIN = -SMAX - rnd_t'(1);

    // One extra bit of headroom keeps the half-LSB add from overflowing.
    function automatic rnd_t round_shift(input logic [SAXI_DATA_WIDTH-1:0] din, input int shift);
        rnd_t t;
        t = rnd_t'({din[SAXI_DATA_WIDTH-1], din}) + (rnd_t'(1) <<< (shift - 1));
        return t >>> shift;
    endfunction

    function automatic sat_t saturate(input rnd_t r);
        sat_t s;
        s.sat = r > SMAX || r < SMIN;
        s.dout = r > SMAX ? OUT_MAX : r < SMIN ? OUT_MIN : r[MAXI_DATA_WIDTH-1:0];
        return s;
    endfunction

    function automatic sat_t round_sat(input logic [SAXI_DATA_WIDTH-1:0] din, input int shift);
        return saturate(round_shift(din, shift));
    endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one-deep valid/ready register that accepts whenever empty or draining.
module axis_reg_slice #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid <= 1'b0;
            m_data <= '0;
        end else if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) m_data <= s_data;
        end
    end
endmodule

// File: rtl/fir_round_decim.sv
// fir_round_decim: rounds 32-bit FIR results to 16 bits, saturates and decimates over AXI-Stream.
module fir_round_decim
    import fir_pkg::*;
#(
    parameter int SHIFT = 15,
    parameter int DECIM_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [SAXI_DATA_WIDTH-1:0] s_axis_rnd_tdata_i,
    input  logic [S_KEEP_WIDTH-1:0]    s_axis_rnd_tkeep_i,
    input  logic                       s_axis_rnd_tlast_i,
    input  logic                       s_axis_rnd_tvalid_i,
    output logic                       s_axis_rnd_tready_o,
    output logic [MAXI_DATA_WIDTH-1:0] m_axis_rnd_tdata_o,
    output logic [M_KEEP_WIDTH-1:0]    m_axis_rnd_tkeep_o,
    output logic                       m_axis_rnd_tlast_o,
    output logic                       m_axis_rnd_tvalid_o,
    input  logic                       m_axis_rnd_tready_i,
    input  logic [DECIM_W-1:0]         decim_ratio_i,
    input  logic                       sat_clr_i,
    output logic                       sat_flag_o
);
    logic [DECIM_W-1:0] cnt, r_lat, r_eff;
    logic s1_ready, s1_valid, s1_last, s2_ready, accept, keep, unused;
    rnd_t s1_r;
    sat_t s2_in;

    assign unused = ^s_axis_rnd_tkeep_i;
    assign r_eff = decim_ratio_i == '0 ? DECIM_W'(1) : decim_ratio_i;
    assign s_axis_rnd_tready_o = !rst_i && s1_ready;
    assign accept = s_axis_rnd_tvalid_i && s_axis_rnd_tready_o;
    assign keep = s_axis_rnd_tlast_i || cnt == '0;
    assign s2_in = saturate(s1_r);
    assign m_axis_rnd_tkeep_o = {M_KEEP_WIDTH{m_axis_rnd_tvalid_o}};

    // Dropped beats are still consumed; they simply never enter S1.
    axis_reg_slice #(.W(RND_W + 1)) u_s1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_valid (s_axis_rnd_tvalid_i && keep),
        .s_ready (s1_ready),
        .s_data  ({s_axis_rnd_tlast_i, round_shift(s_axis_rnd_tdata_i, SHIFT)}),
        .m_valid (s1_valid),
        .m_ready (s2_ready),
        .m_data  ({s1_last, s1_r})
    );

    axis_reg_slice #(.W(MAXI_DATA_WIDTH + 1)) u_s2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_valid (s1_valid),
        .s_ready (s2_ready),
        .s_data  ({s1_last, s2_in.dout}),
        .m_valid (m_axis_rnd_tvalid_o),
        .m_ready (m_axis_rnd_tready_i),
        .m_data  ({m_axis_rnd_tlast_o, m_axis_rnd_tdata_o})
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            r_lat <= DECIM_W'(1);
            sat_flag_o <= 1'b0;
        end else begin
            if (accept) begin
                if (cnt == '0) r_lat <= r_eff;
                cnt <= s_axis_rnd_tlast_i ? '0
                     : cnt == '0 ? (r_eff == DECIM_W'(1) ? '0 : DECIM_W'(1))
                     : cnt == r_lat - DECIM_W'(1) ? '0 : cnt + DECIM_W'(1);
            end
            if (s1_valid && s2_ready && s2_in.sat) sat_flag_o <= 1'b1;
            else if (sat_clr_i) sat_flag_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_round_decim.sv
// tb_fir_round_decim: randomized and directed checks of rounding, saturation, decimation and backpressure.
module tb_fir_round_decim;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0] s_tkeep = '0;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
    logic [15:0] m_tdata;
    logic [1:0] m_tkeep;
    logic m_tlast, m_tvalid;
    logic m_tready = 1'b1;
    logic [7:0] decim = 8'd1;
    logic sat_clr = 1'b0, sat_flag;

    int checks = 0, errors = 0;
    logic [16:0] rx[$], exp_q[$];
    int seg = 0, r_model = 1, stalls = 0, stab_err = 0, rdy_err = 0, bp_cnt = 0;
    logic exp_sat = 1'b0, bp_en = 1'b0, hold_prev = 1'b0;
    logic [16:0] prev_beat = '0;
    logic [5:0] pat = 6'b101001;

    always #5 clk = ~clk;

    fir_round_decim dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .s_axis_rnd_tdata_i  (s_tdata),
        .s_axis_rnd_tkeep_i  (s_tkeep),
        .s_axis_rnd_tlast_i  (s_tlast),
        .s_axis_rnd_tvalid_i (s_tvalid),
        .s_axis_rnd_tready_o (s_tready),
        .m_axis_rnd_tdata_o  (m_tdata),
        .m_axis_rnd_tkeep_o  (m_tkeep),
        .m_axis_rnd_tlast_o  (m_tlast),
        .m_axis_rnd_tvalid_o (m_tvalid),
        .m_axis_rnd_tready_i (m_tready),
        .decim_ratio_i       (decim),
        .sat_clr_i           (sat_clr),
        .sat_flag_o          (sat_flag)
    );

    // Reference: exact real-valued half-up rounding, then clamp to int16.
    function automatic logic [16:0] ref_round(input logic [31:0] d);
        real x;
        x = $floor(real'($signed(d)) / 32768.0 + 0.5);
        if (x > 32767.0) return {1'b1, 16'h7fff};
        if (x < -32768.0) return {1'b1, 16'h8000};
        return {1'b0, 16'(int'(x))};
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst) hold_prev = 1'b0;
        else begin
            if (hold_prev && (!m_tvalid || {m_tlast, m_tdata} !== prev_beat)) stab_err++;
            if (!s_tready && (m_tready || !m_tvalid)) rdy_err++;
            if (m_tvalid && m_tready) rx.push_back({m_tlast, m_tdata});
            hold_prev = m_tvalid && !m_tready;
            prev_beat = {m_tlast, m_tdata};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) begin
            m_tready = bp_cnt < 24 ? pat[bp_cnt % 6] : 1'($urandom);
            bp_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        sat_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx.delete();
        exp_q.delete();
        seg = 0;
        exp_sat = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        logic [16:0] m;
        s_tdata = d;
        s_tlast = l;
        s_tkeep = 4'($urandom);
        s_tvalid = 1'b1;
        m = ref_round(d);
        if (l || seg % r_model == 0) begin
            exp_q.push_back({l, m[15:0]});
            exp_sat |= m[16];
        end
        seg = l ? 0 : seg + 1;
        @(negedge clk);
        if (!s_tready) stalls++;
        while (!s_tready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_tready=%b required 1", s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rx.size() < exp_q.size() && n < 2000) begin
            n++;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks += 6;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
        if (m_tdata !== 16'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0000", m_tdata); end
        if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", m_tlast); end
        if (m_tkeep !== 2'b00) begin errors++; $display("FAIL reset_tkeep: got %b required 00", m_tkeep); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b required 0", sat_flag); end
        if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b required 0", s_tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round();
        logic [16:0] want[3] = '{17'h00001, 17'h00000, 17'h00000};
        do_reset();
        decim = 8'd1;
        r_model = 1;
        send(32'h0000_4000, 1'b0);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: tvalid %b required 0", m_tvalid); end
        @(negedge clk);
        checks += 2;
        if (m_tvalid !== 1'b1) begin errors++; $display("FAIL latency_2clk: tvalid %b required 1", m_tvalid); end
        if (m_tkeep !== 2'b11) begin errors++; $display("FAIL tkeep: got %b required 11", m_tkeep); end
        @(posedge clk);
        #1;
        send(32'h0000_3fff, 1'b0);
        send(32'hffff_c000, 1'b0);
        drain();
        checks += 2;
        if (rx.size() != 3) begin errors++; $display("FAIL round_count: got %0d required 3", rx.size()); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_sat: got %b required 0", sat_flag); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== want[i]) begin errors++; $display("FAIL round_%0d: got %h required %h", i, rx[i], want[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [16:0] want[2] = '{17'h07fff, 17'h08000};
        int n = 0;
        do_reset();
        send(32'h7fff_ffff, 1'b0);
        send(32'h8000_0000, 1'b0);
        drain();
        checks += 2;
        if (rx.size() != 2) begin errors++; $display("FAIL sat_count: got %0d required 2", rx.size()); end
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b required 1", sat_flag); end
        for (int i = 0; i < 2 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== want[i]) begin errors++; $display("FAIL sat_%0d: got %h required %h", i, rx[i], want[i]); end
        end
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b required 0", sat_flag); end
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        send(32'h7fff_ffff, 1'b0);
        @(negedge clk);
        while (!m_tvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!m_tvalid || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_set_wins: tvalid=%b flag=%b required 1,1", m_tvalid, sat_flag);
        end
        sat_clr = 1'b0;
        drain();
    endtask

    task automatic test_decim();
        logic [16:0] want[3] = '{17'd0, 17'd4, 17'd8};
        do_reset();
        decim = 8'd4;
        r_model = 4;
        stalls = 0;
        for (int k = 0; k < 12; k++) send(32'(k) << 15, 1'b0);
        drain();
        checks += 2;
        if (rx.size() != 3) begin errors++; $display("FAIL decim_count: got %0d required 3", rx.size()); end
        if (stalls != 0) begin errors++; $display("FAIL decim_tready: %0d stalls required 0", stalls); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== want[i]) begin errors++; $display("FAIL decim_%0d: got %h required %h", i, rx[i], want[i]); end
        end
    endtask

    task automatic test_tlast();
        logic [16:0] want[4] = '{17'd0, 17'd4, {1'b1, 16'd6}, 17'd7};
        do_reset();
        decim = 8'd4;
        r_model = 4;
        for (int k = 0; k < 10; k++) send(32'(k) << 15, k == 6);
        drain();
        checks++;
        if (rx.size() != 4) begin errors++; $display("FAIL tlast_count: got %0d required 4", rx.size()); end
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== want[i]) begin errors++; $display("FAIL tlast_%0d: got %h required %h", i, rx[i], want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        decim = 8'd1;
        r_model = 1;
        stab_err = 0;
        rdy_err = 0;
        bp_cnt = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) send($urandom_range(0, 3) == 0 ? $urandom : 32'(i) << 15, 1'($urandom_range(0, 7) == 0));
        drain();
        bp_en = 1'b0;
        m_tready = 1'b1;
        checks += 4;
        if (rx.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", rx.size(), exp_q.size()); end
        if (stab_err != 0) begin errors++; $display("FAIL b2b_stable: %0d hold violations required 0", stab_err); end
        if (rdy_err != 0) begin errors++; $display("FAIL b2b_tready: %0d bad stalls required 0", rdy_err); end
        if (sat_flag !== exp_sat) begin errors++; $display("FAIL b2b_sat: got %b required %b", sat_flag, exp_sat); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_%0d: got %h required %h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_r0_reset();
        int n = 0;
        do_reset();
        decim = 8'd0;
        r_model = 1;
        for (int i = 0; i < 6; i++) send($urandom, 1'b0);
        drain();
        checks++;
        if (rx.size() != 6) begin errors++; $display("FAIL r0_count: got %0d required 6", rx.size()); end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== exp_q[i]) begin errors++; $display("FAIL r0_%0d: got %h required %h", i, rx[i], exp_q[i]); end
        end
        m_tready = 1'b0;
        send(32'h7fff_ffff, 1'b0);
        @(negedge clk);
        while (!m_tvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!m_tvalid || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: tvalid=%b flag=%b required 1,1", m_tvalid, sat_flag);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_tvalid: got %b required 0", m_tvalid); end
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL mid_reset_sat: got %b required 0", sat_flag); end
        m_tready = 1'b1;
        rx.delete();
        exp_q.delete();
        seg = 0;
        decim = 8'd3;
        r_model = 3;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) send(32'(k) << 15, 1'b0);
        drain();
        checks++;
        if (rx.size() != 1 || rx[0] !== 17'd1) begin
            errors++;
            $display("FAIL post_reset_first: got %0d beats first %h required 1 beat 00001", rx.size(), rx.size() ? rx[0] : 17'h0);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_saturate();
        test_decim();
        test_tlast();
        test_back_to_back();
        test_r0_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
